kmeans_centroid_update_k2_d2: RTL and testbench

KMEANS_CENTROID_UPDATE_K2_D2 -- requirements
Module: kmeans_centroid_update_k2_d2

---
 rtl/kmeans_pkg.sv | 36 +++
 rtl/kmeans_seq_divider.sv | 76 +++++++
 rtl/kmeans_centroid_update_k2_d2.sv | 223 ++++++++++++++++++++++
 tb/tb_kmeans_centroid_update_k2_d2.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_pkg.sv
// kmeans_pkg -- shared definitions for the k=2, d=2 centroid update block.
//
// Contents:
//   state_t       : update FSM states (ACCUM is the reset state)
//   KM_SW         : accumulator (sum) width at default parameters
//   KM_CNT_W      : per-cluster sample count width at default parameters
//   KM_ROUND      : 1 when KMEANS_UPDATE_ROUND_EN is defined (round-half-up)
//   KM_DIV_W      : dividend width seen by the shared divider
//   KM_DIV_CYCLES : cycles per division (1 load + KM_DIV_W iterations)
//   KM_LATENCY    : triggering-sample acceptance edge to out_valid edge
//
// Optional feature macro: KMEANS_UPDATE_ROUND_EN
package kmeans_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV   = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int KM_DATA_W = 8;
  localparam int KM_QTY_W  = 8;
  localparam int KM_SW     = KM_DATA_W + KM_QTY_W;
  localparam int KM_CNT_W  = KM_QTY_W + 1;

`ifdef KMEANS_UPDATE_ROUND_EN
  localparam int KM_ROUND = 1;
`else
  localparam int KM_ROUND = 0;
`endif

  localparam int KM_DIV_W      = KM_SW + KM_ROUND;
  localparam int KM_DIV_CYCLES = KM_DIV_W + 1;
  localparam int KM_LATENCY    = 4 * KM_DIV_CYCLES + 1;

endpackage

// File: rtl/kmeans_seq_divider.sv
// kmeans_seq_divider -- sequential restoring unsigned divider.
//
// A start pulse loads the operands (one cycle); the quotient is then built
// one bit per cycle over DVD_W cycles. done pulses for one cycle when the
// quotient is final and stays valid until the next start.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset (aborts a division)
//   start      : load dividend/divisor and begin
//   dividend   : DVD_W-bit unsigned dividend
//   divisor    : DVS_W-bit unsigned divisor (zero gives a meaningless result)
//   quotient   : low QUO_W bits of the quotient
//   done       : one-cycle pulse, quotient valid
module kmeans_seq_divider #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 9,
  parameter int QUO_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [QUO_W-1:0] quotient,
  output logic             done
);

  localparam int STEP_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0]  rem_reg;
  logic [DVD_W-1:0]  quo_reg;
  logic [STEP_W-1:0] step_reg;
  logic              busy_reg;
  logic              done_reg;

  // Partial remainder shifted left with the next dividend bit. The remainder
  // is always below the divisor, so DVS_W+1 bits hold the trial value and
  // the difference, when taken, fits back into DVS_W bits.
  logic [DVS_W:0]   trial;
  logic [DVS_W-1:0] diff;
  logic             fits;

  assign trial = {rem_reg, quo_reg[DVD_W-1]};
  assign fits  = trial >= {1'b0, divisor};
  assign diff  = trial[DVS_W-1:0] - divisor;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      step_reg <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        rem_reg  <= '0;
        quo_reg  <= dividend;
        step_reg <= STEP_W'(DVD_W);
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        rem_reg  <= fits ? diff : trial[DVS_W-1:0];
        quo_reg  <= {quo_reg[DVD_W-2:0], fits};
        step_reg <= step_reg - 1'b1;
        if (step_reg == STEP_W'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_reg[QUO_W-1:0];
  assign done     = done_reg;

endmodule

// File: rtl/kmeans_centroid_update_k2_d2.sv
// kmeans_centroid_update_k2_d2 -- k-means centroid update, 2 clusters x 2 dims.
//
// Accumulates per-cluster coordinate sums and counts for one iteration, then
// computes the four means with one shared sequential divider (k0d0, k0d1,
// k1d0, k1d1) and publishes them with a one-cycle out_valid pulse. Empty
// clusters keep their old centroid and are flagged in empty_cluster.
// Latency from the triggering sample's acceptance edge to out_valid is fixed.
//
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   in_valid / in_ready     : sample handshake (ready only while accumulating)
//   in_data0, in_data1      : sample coordinates
//   in_centroid             : nearest-centroid index of the sample
//   in_last                 : final sample of the iteration
//   old_k*d*                : current centroids (fallback for empty clusters)
//   new_k*d*                : updated centroids, held between pulses
//   out_valid               : one-cycle pulse when new_* are updated
//   empty_cluster           : bit c set when cluster c received no samples
//
// Optional feature macro: KMEANS_UPDATE_ROUND_EN (round-half-up means).
module kmeans_centroid_update_k2_d2
  import kmeans_pkg::*;
#(
  parameter int input_data_width         = 8,
  parameter int input_data_qty_bit_width = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [input_data_width-1:0] in_data0,
  input  logic [input_data_width-1:0] in_data1,
  input  logic                        in_centroid,
  input  logic                        in_last,
  input  logic [input_data_width-1:0] old_k0d0,
  input  logic [input_data_width-1:0] old_k0d1,
  input  logic [input_data_width-1:0] old_k1d0,
  input  logic [input_data_width-1:0] old_k1d1,
  output logic [input_data_width-1:0] new_k0d0,
  output logic [input_data_width-1:0] new_k0d1,
  output logic [input_data_width-1:0] new_k1d0,
  output logic [input_data_width-1:0] new_k1d1,
  output logic                        out_valid,
  output logic [1:0]                  empty_cluster
);

  localparam int W         = input_data_width;
  localparam int Q         = input_data_qty_bit_width;
  localparam int SUM_W     = W + Q;
  localparam int CNT_W     = Q + 1;
  localparam int DVD_W     = SUM_W + KM_ROUND;
  localparam int DIV_STEPS = DVD_W + 1;
  localparam int PH_W      = $clog2(DIV_STEPS);

  localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(DIV_STEPS - 1);
  // Total count just before reaching 2^Q: the sample accepted now is the last.
  localparam logic [CNT_W-1:0] LAST_TOTAL = {1'b0, {Q{1'b1}}};

  state_t           state_reg;
  logic [CNT_W-1:0] total_reg;
  logic [1:0]       idx_reg;
  logic [PH_W-1:0]  phase_reg;
  logic [W-1:0]     q_reg [3];

  logic [W-1:0] new_k0d0_reg, new_k0d1_reg, new_k1d0_reg, new_k1d1_reg;
  logic [1:0]   empty_reg;
  logic         out_valid_reg;

  logic             accept;
  logic [SUM_W-1:0] sum_d0 [2];
  logic [SUM_W-1:0] sum_d1 [2];
  logic [CNT_W-1:0] cnt    [2];
  logic [1:0]       empty_now;

  assign in_ready = (state_reg == ACCUM);
  assign accept   = in_valid && in_ready;

  // Per-cluster accumulators; cleared when results are published.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cluster
      logic [SUM_W-1:0] sum_d0_reg;
      logic [SUM_W-1:0] sum_d1_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             hit;

      assign hit = accept && (in_centroid == 1'(gi));

      always_ff @(posedge clk) begin
        if (rst || state_reg == DONE) begin
          sum_d0_reg <= '0;
          sum_d1_reg <= '0;
          cnt_reg    <= '0;
        end else if (hit) begin
          sum_d0_reg <= sum_d0_reg + {{Q{1'b0}}, in_data0};
          sum_d1_reg <= sum_d1_reg + {{Q{1'b0}}, in_data1};
          cnt_reg    <= cnt_reg + 1'b1;
        end
      end

      assign sum_d0[gi]    = sum_d0_reg;
      assign sum_d1[gi]    = sum_d1_reg;
      assign cnt[gi]       = cnt_reg;
      assign empty_now[gi] = (cnt_reg == '0);
    end
  endgenerate

  // Operand selection for the division currently scheduled by idx_reg.
  logic [SUM_W-1:0] div_sum;
  logic [CNT_W-1:0] div_cnt;
  logic [DVD_W-1:0] div_dividend;
  logic             div_start;
  logic [W-1:0]     div_quotient;
  logic             div_done;

  always_comb begin
    div_sum = sum_d0[0];
    div_cnt = cnt[0];
    case (idx_reg)
      2'd0: begin div_sum = sum_d0[0]; div_cnt = cnt[0]; end
      2'd1: begin div_sum = sum_d1[0]; div_cnt = cnt[0]; end
      2'd2: begin div_sum = sum_d0[1]; div_cnt = cnt[1]; end
      default: begin div_sum = sum_d1[1]; div_cnt = cnt[1]; end
    endcase
  end

`ifdef KMEANS_UPDATE_ROUND_EN
  // Adding half the count before dividing rounds the mean half-up.
  assign div_dividend = {1'b0, div_sum} + DVD_W'(div_cnt >> 1);
`else
  assign div_dividend = div_sum;
`endif

  // Each division starts at phase 0, so the four slots run back to back.
  assign div_start = (state_reg == DIV) && (phase_reg == '0);

  kmeans_seq_divider #(
    .DVD_W (DVD_W),
    .DVS_W (CNT_W),
    .QUO_W (W)
  ) u_divider (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_cnt),
    .quotient (div_quotient),
    .done     (div_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ACCUM;
      total_reg     <= '0;
      idx_reg       <= '0;
      phase_reg     <= '0;
      q_reg[0]      <= '0;
      q_reg[1]      <= '0;
      q_reg[2]      <= '0;
      new_k0d0_reg  <= '0;
      new_k0d1_reg  <= '0;
      new_k1d0_reg  <= '0;
      new_k1d1_reg  <= '0;
      empty_reg     <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= 1'b0;
      case (state_reg)
        ACCUM: begin
          if (accept) begin
            total_reg <= total_reg + 1'b1;
            if (in_last || total_reg == LAST_TOTAL) begin
              state_reg <= DIV;
              idx_reg   <= '0;
              phase_reg <= '0;
            end
          end
        end
        DIV: begin
          // done of slot i-1 coincides with the load cycle of slot i.
          if (div_done) begin
            case (idx_reg)
              2'd1:    q_reg[0] <= div_quotient;
              2'd2:    q_reg[1] <= div_quotient;
              2'd3:    q_reg[2] <= div_quotient;
              default: ;
            endcase
          end
          if (phase_reg == LAST_PHASE) begin
            phase_reg <= '0;
            if (idx_reg == 2'd3) begin
              state_reg <= DONE;
            end else begin
              idx_reg <= idx_reg + 2'd1;
            end
          end else begin
            phase_reg <= phase_reg + 1'b1;
          end
        end
        DONE: begin
          // The fourth quotient is taken straight from the divider here.
          new_k0d0_reg  <= empty_now[0] ? old_k0d0 : q_reg[0];
          new_k0d1_reg  <= empty_now[0] ? old_k0d1 : q_reg[1];
          new_k1d0_reg  <= empty_now[1] ? old_k1d0 : q_reg[2];
          new_k1d1_reg  <= empty_now[1] ? old_k1d1 : div_quotient;
          empty_reg     <= empty_now;
          out_valid_reg <= 1'b1;
          total_reg     <= '0;
          state_reg     <= ACCUM;
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

  assign new_k0d0      = new_k0d0_reg;
  assign new_k0d1      = new_k0d1_reg;
  assign new_k1d0      = new_k1d0_reg;
  assign new_k1d1      = new_k1d1_reg;
  assign empty_cluster = empty_reg;
  assign out_valid     = out_valid_reg;

endmodule

// File: tb/tb_kmeans_centroid_update_k2_d2.sv
// tb_kmeans_centroid_update_k2_d2 -- self-checking bench for the centroid
// update block: directed vector table, hand-written corner sequences
// (auto-trigger at full count, reset during division, noisy inputs during
// division) and randomized iterations checked against a mean model.
module tb_kmeans_centroid_update_k2_d2;
  import kmeans_pkg::*;

`ifdef KMEANS_UPDATE_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data0, in_data1;
  logic       in_centroid;
  logic       in_last;
  logic [7:0] old_k0d0, old_k0d1, old_k1d0, old_k1d1;
  logic [7:0] new_k0d0, new_k0d1, new_k1d0, new_k1d1;
  logic       out_valid;
  logic [1:0] empty_cluster;

  always #5 clk = ~clk;

  kmeans_centroid_update_k2_d2 #(
    .input_data_width         (8),
    .input_data_qty_bit_width (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data0      (in_data0),
    .in_data1      (in_data1),
    .in_centroid   (in_centroid),
    .in_last       (in_last),
    .old_k0d0      (old_k0d0),
    .old_k0d1      (old_k0d1),
    .old_k1d0      (old_k1d0),
    .old_k1d1      (old_k1d1),
    .new_k0d0      (new_k0d0),
    .new_k0d1      (new_k0d1),
    .new_k1d0      (new_k1d0),
    .new_k1d1      (new_k1d1),
    .out_valid     (out_valid),
    .empty_cluster (empty_cluster)
  );

  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][7:0] d0;
    logic [3:0][7:0] d1;
    logic [3:0]      c;
    logic [3:0][7:0] old;
    logic [3:0][7:0] exp_new;
    logic [1:0]      exp_empty;
  } vec_t;

  vec_t tbl [4];

  int tests_run    = 0;
  int tests_failed = 0;

  int q_d0 [$];
  int q_d1 [$];
  int q_c  [$];
  int o    [4];
  int e    [4];
  int e_emp;
  int lat;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Mean of each cluster's coordinates from the sample list; empty -> old.
  task automatic model();
    for (int c = 0; c < 2; c++) begin
      int s0 = 0;
      int s1 = 0;
      int n  = 0;
      for (int i = 0; i < q_c.size(); i++) begin
        if (q_c[i] == c) begin
          s0 += q_d0[i];
          s1 += q_d1[i];
          n++;
        end
      end
      if (n == 0) begin
        e[2*c]   = o[2*c];
        e[2*c+1] = o[2*c+1];
      end else begin
        e[2*c]   = ((s0 + (ROUND ? n / 2 : 0)) / n) % 256;
        e[2*c+1] = ((s1 + (ROUND ? n / 2 : 0)) / n) % 256;
      end
    end
    e_emp = ((q_c.size() - q_c.sum()) == 0 ? 1 : 0) + (q_c.sum() == 0 ? 2 : 0);
  endtask

  task automatic clear_q();
    q_d0.delete();
    q_d1.delete();
    q_c.delete();
  endtask

  task automatic push(input int d0, input int d1, input int c);
    q_d0.push_back(d0);
    q_d1.push_back(d1);
    q_c.push_back(c);
  endtask

  // Drive all queued samples back to back; returns at the triggering
  // sample's acceptance edge + 1.
  task automatic send_samples(input bit use_last);
    old_k0d0 = 8'(o[0]);
    old_k0d1 = 8'(o[1]);
    old_k1d0 = 8'(o[2]);
    old_k1d1 = 8'(o[3]);
    for (int i = 0; i < q_c.size(); i++) begin
      in_valid    = 1'b1;
      in_data0    = 8'(q_d0[i]);
      in_data1    = 8'(q_d1[i]);
      in_centroid = 1'(q_c[i]);
      in_last     = use_last && (i == q_c.size() - 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_iter(input bit use_last, input bit noisy, input string tag);
    bit seen;
    send_samples(use_last);
    chk({tag, " in_ready_in_div"}, int'(in_ready), 0);
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 400) begin
      if (noisy) begin
        in_valid    = 1'b1;
        in_data0    = 8'($urandom);
        in_data1    = 8'($urandom);
        in_centroid = 1'($urandom);
        in_last     = 1'($urandom);
      end
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) seen = 1'b1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!seen) begin
      chk({tag, " out_valid_timeout"}, 0, 1);
    end else begin
      chk({tag, " latency"}, lat, KM_LATENCY);
      chk({tag, " new_k0d0"}, int'(new_k0d0), e[0]);
      chk({tag, " new_k0d1"}, int'(new_k0d1), e[1]);
      chk({tag, " new_k1d0"}, int'(new_k1d0), e[2]);
      chk({tag, " new_k1d1"}, int'(new_k1d1), e[3]);
      chk({tag, " empty_cluster"}, int'(empty_cluster), e_emp);
      @(posedge clk);
      #1;
      chk({tag, " out_valid_pulse_width"}, int'(out_valid), 0);
      chk({tag, " in_ready_after"}, int'(in_ready), 1);
      chk({tag, " hold_k1d1"}, int'(new_k1d1), e[3]);
    end
    $display("[TB] %s: n=%0d lat=%0d new=(%0d,%0d),(%0d,%0d) empty=%b",
             tag, q_c.size(), lat, new_k0d0, new_k0d1, new_k1d0, new_k1d1, empty_cluster);
  endtask

  task automatic load_vec(input int v);
    clear_q();
    for (int i = 0; i < int'(tbl[v].n); i++)
      push(int'(tbl[v].d0[i]), int'(tbl[v].d1[i]), int'(tbl[v].c[i]));
    for (int k = 0; k < 4; k++) begin
      o[k] = int'(tbl[v].old[k]);
      e[k] = int'(tbl[v].exp_new[k]);
    end
    e_emp = int'(tbl[v].exp_empty);
  endtask

  task automatic set_smp(input int v, input int i, input int d0, input int d1, input int c);
    tbl[v].d0[i] = 8'(d0);
    tbl[v].d1[i] = 8'(d1);
    tbl[v].c[i]  = 1'(c);
  endtask

  task automatic set_exp(input int v, input int a, input int b, input int c, input int d,
                         input int emp);
    tbl[v].exp_new[0] = 8'(a);
    tbl[v].exp_new[1] = 8'(b);
    tbl[v].exp_new[2] = 8'(c);
    tbl[v].exp_new[3] = 8'(d);
    tbl[v].exp_empty  = 2'(emp);
  endtask

  task automatic set_old(input int v, input int a, input int b, input int c, input int d);
    tbl[v].old[0] = 8'(a);
    tbl[v].old[1] = 8'(b);
    tbl[v].old[2] = 8'(c);
    tbl[v].old[3] = 8'(d);
  endtask

  initial begin
    int pulses;

    // Directed vectors: samples, old centroids, expected results.
    for (int v = 0; v < 4; v++) tbl[v] = '0;
    tbl[0].n = 3'd3;
    set_smp(0, 0, 2, 4, 0);
    set_smp(0, 1, 4, 6, 0);
    set_smp(0, 2, 10, 10, 1);
    set_old(0, 0, 0, 0, 0);
    set_exp(0, 3, 5, 10, 10, 0);

    tbl[1].n = 3'd3;
    set_smp(1, 0, 3, 6, 0);
    set_smp(1, 1, 6, 9, 0);
    set_smp(1, 2, 9, 12, 0);
    set_old(1, 50, 50, 1, 1);
    set_exp(1, 6, 9, 1, 1, 2);

    tbl[2].n = 3'd2;
    set_smp(2, 0, 1, 1, 0);
    set_smp(2, 1, 2, 2, 0);
    set_old(2, 0, 0, 7, 8);
    set_exp(2, ROUND ? 2 : 1, ROUND ? 2 : 1, 7, 8, 2);

    tbl[3].n = 3'd1;
    set_smp(3, 0, 200, 100, 1);
    set_old(3, 9, 9, 0, 0);
    set_exp(3, 9, 9, 200, 100, 1);

    rst = 1'b1;
    in_valid = 1'b0;
    in_data0 = '0;
    in_data1 = '0;
    in_centroid = 1'b0;
    in_last = 1'b0;
    old_k0d0 = '0;
    old_k0d1 = '0;
    old_k1d0 = '0;
    old_k1d1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset new_k0d0", int'(new_k0d0), 0);
    chk("reset new_k1d1", int'(new_k1d1), 0);
    chk("reset empty_cluster", int'(empty_cluster), 0);

    for (int v = 0; v < 4; v++) begin
      load_vec(v);
      run_iter(1'b1, 1'b0, $sformatf("vec%0d", v));
    end

    // Full iteration without in_last: divides automatically at 2^8 samples.
    clear_q();
    for (int i = 0; i < 256; i++) push(255, 255, 1);
    o = '{12, 34, 0, 0};
    e = '{12, 34, 255, 255};
    e_emp = 1;
    run_iter(1'b0, 1'b0, "full256");

    // Reset 10 cycles into the division phase.
    load_vec(0);
    send_samples(1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort in_ready", int'(in_ready), 1);
    chk("abort new_k0d0", int'(new_k0d0), 0);
    chk("abort new_k1d1", int'(new_k1d1), 0);
    chk("abort empty_cluster", int'(empty_cluster), 0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) pulses++;
    end
    chk("abort out_valid_pulses", pulses, 0);
    $display("[TB] abort: reset during division, %0d out_valid pulses", pulses);
    load_vec(0);
    run_iter(1'b1, 1'b0, "after_abort");

    // Inputs toggling throughout division must not disturb the result.
    load_vec(0);
    run_iter(1'b1, 1'b1, "vec0_noisy");

    // Randomized iterations against the mean model.
    for (int it = 0; it < 20; it++) begin
      int n;
      clear_q();
      n = int'($urandom_range(1, 24));
      for (int i = 0; i < n; i++)
        push(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             (it % 5 == 0) ? (it % 10 == 0 ? 0 : 1) : int'($urandom_range(0, 1)));
      for (int k = 0; k < 4; k++) o[k] = int'($urandom_range(0, 255));
      model();
      run_iter(1'b1, 1'(it % 2), $sformatf("rand%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
